regwb_arbiter: RTL and testbench

Write-back arbiter for the 32-entry register file. It shares the register file's single write port between two write-back requesters: requester 0 (ALU result, older in program order) and requester 1 (load result). It grants at most one real write per cycle with round-robin fairness and registers the winning write onto the `RegWrite`/`write_reg`/`write_data` port. It also exports a per-register pending-write scoreboard so decode can stall on in-flight writes.

---
 rtl/regwb_arbiter_if.sv | 38 +++
 rtl/regwb_arbiter.sv | 129 ++++++++++++
 tb/tb_regwb_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regwb_arbiter_if.sv
// Write-back bus between the two requesters and the register-file write port.
// Carries both requester handshakes, the registered write port and the
// pending-write scoreboard (meaningful only when REGWB_SCOREBOARD_EN is defined).
interface regwb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic                     req0_valid;
  logic [REG_AW-1:0]        req0_reg;
  logic [DATA_W-1:0]        req0_data;
  logic                     req0_ready;
  logic                     req1_valid;
  logic [REG_AW-1:0]        req1_reg;
  logic [DATA_W-1:0]        req1_data;
  logic                     req1_ready;
  logic                     RegWrite;
  logic [REG_AW-1:0]        write_reg;
  logic [DATA_W-1:0]        write_data;
  logic [(2**REG_AW)-1:0]   busy;

  // Requester / register-file side.
  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready,
    input  RegWrite, write_reg, write_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready,
    output RegWrite, write_reg, write_data, busy
  );
endinterface

// File: rtl/regwb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Requester 0 (ALU, older) and requester 1 (load) share the port with a
// round-robin pointer; same-register collisions always favour requester 0 to
// keep program order. Register-0 writes are accepted and silently discarded.
// The winning write is registered onto RegWrite/write_reg/write_data.
// Optional feature macro: REGWB_SCOREBOARD_EN -- when defined, busy carries the
// per-register pending-write scoreboard; when undefined, busy is all zeros.
module regwb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst,
  regwb_arbiter_if.slave      wb
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  logic              real0_s;
  logic              real1_s;
  logic              zero0_s;
  logic              zero1_s;
  logic              same_s;
  logic              grant0_s;
  logic              grant1_s;

  // rr_q names the requester that wins the next contended, non-colliding cycle.
  logic              rr_q;
  logic              rr_d;
  logic              we_q;
  logic              we_d;
  logic [REG_AW-1:0] wreg_q;
  logic [REG_AW-1:0] wreg_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;

  // Classify requests and pick at most one real winner this cycle.
  always_comb begin
    real0_s  = wb.req0_valid && (wb.req0_reg != REG_ZERO);
    real1_s  = wb.req1_valid && (wb.req1_reg != REG_ZERO);
    zero0_s  = wb.req0_valid && (wb.req0_reg == REG_ZERO);
    zero1_s  = wb.req1_valid && (wb.req1_reg == REG_ZERO);
    same_s   = (wb.req0_reg == wb.req1_reg);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (real0_s && real1_s) begin
      // Same destination: older requester first, pointer ignored.
      if (same_s || (rr_q == 1'b0)) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (real0_s) begin
      grant0_s = 1'b1;
    end else if (real1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Register-0 requests never occupy the write slot, so they are always ready.
  assign wb.req0_ready = zero0_s || grant0_s;
  assign wb.req1_ready = zero1_s || grant1_s;

  // Next-state for the pointer and the output stage.
  always_comb begin
    rr_d    = rr_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant0_s) begin
      rr_d    = 1'b1;
      we_d    = 1'b1;
      wreg_d  = wb.req0_reg;
      wdata_d = wb.req0_data;
    end else if (grant1_s) begin
      rr_d    = 1'b0;
      we_d    = 1'b1;
      wreg_d  = wb.req1_reg;
      wdata_d = wb.req1_data;
    end else begin
      rr_d    = rr_q;
      we_d    = 1'b0;
    end
  end

  // Pointer and registered write port; reset drops any staged write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= {REG_AW{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      rr_q    <= rr_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb.RegWrite   = we_q;
  assign wb.write_reg  = wreg_q;
  assign wb.write_data = wdata_q;

`ifdef REGWB_SCOREBOARD_EN
  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] pend0_s;
  logic [NREG-1:0] pend1_s;
  logic [NREG-1:0] stage_s;

  // Pending writes: presented requests plus the write currently on the port.
  always_comb begin
    pend0_s = real0_s ? (ONE_HOT0 << wb.req0_reg) : {NREG{1'b0}};
    pend1_s = real1_s ? (ONE_HOT0 << wb.req1_reg) : {NREG{1'b0}};
    stage_s = we_q    ? (ONE_HOT0 << wreg_q)      : {NREG{1'b0}};
  end

  // Register 0 is hard-wired and never reported busy.
  assign wb.busy = (pend0_s | pend1_s | stage_s) & ~ONE_HOT0;
`else
  assign wb.busy = {NREG{1'b0}};
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Self-checking bench for regwb_arbiter: queue-driven requesters, a
// rule-level reference model compared every cycle, and literal expectations
// on the observed write-port trace for each directed scenario.
module tb_regwb_arbiter;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] r;
    logic [DATA_W-1:0] d;
  } item_t;

  logic clk;
  logic rst;

  regwb_arbiter_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus();

  regwb_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t q0[$];
  item_t q1[$];
  item_t wlog[$];
  int    wcyc[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stall1 = 0;
  bit both_rdy = 1'b0;

  // Reference model state: preferred requester, and the write on the port.
  int                m_turn = 0;
  bit                m_we   = 1'b0;
  logic [REG_AW-1:0] m_reg  = '0;
  logic [DATA_W-1:0] m_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Who wins the write slot, straight from the arbitration rules (-1 = nobody).
  function automatic int winner(input bit v0, input logic [REG_AW-1:0] r0,
                                input bit v1, input logic [REG_AW-1:0] r1, input int turn);
    bit w0;
    bit w1;
    w0 = v0 && (r0 != 0);
    w1 = v1 && (r1 != 0);
    if (w0 && w1) return (r0 == r1) ? 0 : turn;
    if (w0) return 0;
    if (w1) return 1;
    return -1;
  endfunction

  // Every cycle: compare DUT against the model, log writes, then advance the model.
  always @(negedge clk) begin
    int w;
    bit er0;
    bit er1;
    logic [NREG-1:0] eb;
    cyc++;
    if (!rst) begin
      m_turn = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
    end
    w   = winner(bus.req0_valid, bus.req0_reg, bus.req1_valid, bus.req1_reg, m_turn);
    er0 = bus.req0_valid && (bus.req0_reg == 0 || w == 0);
    er1 = bus.req1_valid && (bus.req1_reg == 0 || w == 1);
    eb  = '0;
`ifdef REGWB_SCOREBOARD_EN
    for (int r = 1; r < NREG; r++) begin
      if ((bus.req0_valid && bus.req0_reg == r) || (bus.req1_valid && bus.req1_reg == r) ||
          (m_we && m_reg == r)) eb[r] = 1'b1;
    end
`endif
    chk("req0_ready", bus.req0_ready, er0);
    chk("req1_ready", bus.req1_ready, er1);
    chk("RegWrite", bus.RegWrite, m_we);
    chk("write_reg", bus.write_reg, m_reg);
    chk("write_data", bus.write_data, m_data);
    chk("busy", bus.busy, eb);
    if (rst && bus.RegWrite) begin
      wlog.push_back({bus.write_reg, bus.write_data});
      wcyc.push_back(cyc);
    end
    if (bus.req1_valid && !bus.req1_ready) stall1++;
    if (bus.req0_valid && bus.req0_ready && bus.req1_valid && bus.req1_ready) both_rdy = 1'b1;
    if (rst) begin
      m_we = (w >= 0);
      if (w == 0) begin
        m_reg = bus.req0_reg; m_data = bus.req0_data; m_turn = 1;
      end else if (w == 1) begin
        m_reg = bus.req1_reg; m_data = bus.req1_data; m_turn = 0;
      end
    end
  end

  // Requesters retire their head item on a completed handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.req0_valid && bus.req0_ready) void'(q0.pop_front());
      if (bus.req1_valid && bus.req1_ready) void'(q1.pop_front());
    end
  end

  // Requesters present their queue heads shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      bus.req0_valid = 1'b1; bus.req0_reg = q0[0].r; bus.req0_data = q0[0].d;
    end else begin
      bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    end
    if (q1.size() > 0) begin
      bus.req1_valid = 1'b1; bus.req1_reg = q1[0].r; bus.req1_data = q1[0].d;
    end else begin
      bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push0(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    q0.push_back({r, d});
  endtask

  task automatic push1(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    q1.push_back({r, d});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 50) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, (n < 50), 1'b1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    wlog.delete();
    wcyc.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [REG_AW-1:0] r,
                         input logic [DATA_W-1:0] d);
    if (idx < wlog.size()) begin
      chk({name, "_reg"}, wlog[idx].r, r);
      chk({name, "_data"}, wlog[idx].d, d);
    end else begin
      chk({name, "_missing"}, wlog.size(), idx + 1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
    #1 rst = 1'b0;

    // Reset held with req0 pending, then released.
    push0(5'd5, 32'h11);
    repeat (3) step();
    chk("rst_RegWrite", bus.RegWrite, 1'b0);
    chk("rst_write_reg", bus.write_reg, 5'd0);
    chk("rst_write_data", bus.write_data, 32'h0);
    wlog.delete(); wcyc.delete();
    rst = 1'b1;
    wait_idle("rst");
    chk("rst_log_len", wlog.size(), 1);
    chk_log("rst_w0", 0, 5'd5, 32'h11);

    // Round-robin alternation under sustained contention.
    do_reset();
    push0(5'd3, 32'hA); push0(5'd3, 32'hA1);
    push1(5'd4, 32'hB); push1(5'd4, 32'hB1);
    wait_idle("rr");
    chk("rr_log_len", wlog.size(), 4);
    chk_log("rr_w0", 0, 5'd3, 32'hA);
    chk_log("rr_w1", 1, 5'd4, 32'hB);
    chk_log("rr_w2", 2, 5'd3, 32'hA1);
    chk_log("rr_w3", 3, 5'd4, 32'hB1);
    if (wcyc.size() == 4) chk("rr_back_to_back", wcyc[3] - wcyc[0], 3);

    // Same-register collision with the pointer favouring requester 1.
    do_reset();
    stall1 = 0;
    push0(5'd2, 32'h9); push0(5'd7, 32'h1);
    push1(5'd7, 32'h2);
    wait_idle("col");
    chk("col_log_len", wlog.size(), 3);
    chk_log("col_w0", 0, 5'd2, 32'h9);
    chk_log("col_w1", 1, 5'd7, 32'h1);
    chk_log("col_w2", 2, 5'd7, 32'h2);
    chk("col_busy_idle", bus.busy, 32'h0);

    // Register 0 alongside a real write.
    do_reset();
    both_rdy = 1'b0;
    push0(5'd0, 32'h77);
    push1(5'd9, 32'h55);
    wait_idle("r0");
    chk("r0_both_ready", both_rdy, 1'b1);
    chk("r0_log_len", wlog.size(), 1);
    chk_log("r0_w0", 0, 5'd9, 32'h55);

    // Back-pressure: req1 held two cycles behind same-register req0 traffic.
    do_reset();
    stall1 = 0;
    push0(5'd6, 32'h1); push0(5'd6, 32'h2);
    push1(5'd6, 32'hCC);
    wait_idle("bp");
    chk("bp_stall_cycles", stall1, 2);
    chk("bp_log_len", wlog.size(), 3);
    chk_log("bp_w0", 0, 5'd6, 32'h1);
    chk_log("bp_w1", 1, 5'd6, 32'h2);
    chk_log("bp_w2", 2, 5'd6, 32'hCC);

    // Reset drops a staged write; pending requests re-arbitrate from pointer 0.
    do_reset();
    push0(5'd8, 32'h42);
    n = 0;
    while (q0.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("drop_timeout", (n < 20), 1'b1);
    chk("drop_staged", bus.RegWrite, 1'b1);
    rst = 1'b0;
    #1;
    chk("drop_RegWrite", bus.RegWrite, 1'b0);
    chk("drop_write_reg", bus.write_reg, 5'd0);
    chk("drop_write_data", bus.write_data, 32'h0);
    push0(5'd10, 32'h1);
    push1(5'd11, 32'h2);
    repeat (2) step();
    rst = 1'b1;
    wait_idle("rearb");
    chk("rearb_log_len", wlog.size(), 2);
    chk_log("rearb_w0", 0, 5'd10, 32'h1);
    chk_log("rearb_w1", 1, 5'd11, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
